// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
package branch_predictor_pkg;

   typedef logic [31:0] word_t;

   localparam int BP_MODE_STATIC  = 0;
   localparam int BP_MODE_DYNAMIC = 1;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Pure saturating up/down next-value logic, shared by the direction and statistics counters.
module bp_sat_counter #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] value,
   input  logic             inc,
   input  logic             dec,
   output logic [WIDTH-1:0] next
);

   function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] v,
                                                 input logic up, input logic down);
      logic [WIDTH-1:0] r;
      r = v;
      if (up && !down && (v != {WIDTH{1'b1}}))
         r = v + 1'b1;
      else if (down && !up && (v != {WIDTH{1'b0}}))
         r = v - 1'b1;
      return r;
   endfunction

   assign next = sat_step(value, inc, dec);

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters and
// saturating prediction statistics; lookup is combinational on the registered table.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int INDEX_BITS = 4,
   parameter int CTR_BITS   = 2,
   parameter int MODE       = BP_MODE_DYNAMIC,
   parameter int STAT_WIDTH = 16
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  word_t                 lk_pc,
   output logic                  lk_hit,
   output logic                  lk_taken,
   output word_t                 lk_target,
   input  logic                  upd_valid,
   input  word_t                 upd_pc,
   input  logic                  upd_taken,
   input  word_t                 upd_target,
   input  logic                  upd_pred_taken,
   input  word_t                 upd_pred_target,
   input  logic                  clear,
   output logic                  mispredict,
   output logic [STAT_WIDTH-1:0] stat_branches,
   output logic [STAT_WIDTH-1:0] stat_mispredicts
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_W   = 30 - INDEX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));

   typedef struct packed {
      logic                valid;
      logic [TAG_W-1:0]    tag;
      word_t               target;
      logic [CTR_BITS-1:0] ctr;
   } btb_entry_t;

   btb_entry_t            tbl [ENTRIES];
   logic [CTR_BITS-1:0]   ctr_next [ENTRIES];
   logic [INDEX_BITS-1:0] lk_idx;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [TAG_W-1:0]      lk_tag;
   logic [TAG_W-1:0]      upd_tag;
   btb_entry_t            lk_entry;
   btb_entry_t            upd_entry;
   logic                  upd_hit;
   logic [STAT_WIDTH-1:0] br_next;
   logic [STAT_WIDTH-1:0] mp_next;
   logic [1:0]            unused_pc_bits;

   assign unused_pc_bits = upd_pc[1:0];

   assign lk_idx   = lk_pc[INDEX_BITS+1:2];
   assign lk_tag   = lk_pc[31:INDEX_BITS+2];
   assign upd_idx  = upd_pc[INDEX_BITS+1:2];
   assign upd_tag  = upd_pc[31:INDEX_BITS+2];
   assign lk_entry  = tbl[lk_idx];
   assign upd_entry = tbl[upd_idx];
   assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

   // No bypass: a same-cycle update becomes visible only after the clock edge.
   assign lk_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
   assign lk_taken  = lk_hit && lk_entry.ctr[CTR_BITS-1] && (MODE == BP_MODE_DYNAMIC);
   assign lk_target = lk_taken ? lk_entry.target : lk_pc + 32'd4;

   assign mispredict = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

   for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
      bp_sat_counter #(.WIDTH(CTR_BITS)) u_ctr (
         .value (tbl[i].ctr),
         .inc   (upd_taken),
         .dec   (!upd_taken),
         .next  (ctr_next[i])
      );
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i].valid  <= 1'b0;
            tbl[i].tag    <= '0;
            tbl[i].target <= '0;
            tbl[i].ctr    <= CTR_WNT;
         end
      end else if (clear) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i].valid <= 1'b0;
            tbl[i].ctr   <= CTR_WNT;
         end
      end else if (upd_valid) begin
         if (upd_hit) begin
            tbl[upd_idx].ctr <= ctr_next[upd_idx];
            if (upd_taken)
               tbl[upd_idx].target <= upd_target;
         end else if (upd_taken) begin
            tbl[upd_idx].valid  <= 1'b1;
            tbl[upd_idx].tag    <= upd_tag;
            tbl[upd_idx].target <= upd_target;
            tbl[upd_idx].ctr    <= CTR_WT;
         end
      end
   end

   bp_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_br (
      .value (stat_branches),
      .inc   (upd_valid),
      .dec   (1'b0),
      .next  (br_next)
   );

   bp_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_mp (
      .value (stat_mispredicts),
      .inc   (mispredict),
      .dec   (1'b0),
      .next  (mp_next)
   );

   // Statistics keep counting through clear; only nRST zeroes them.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         stat_branches    <= br_next;
         stat_mispredicts <= mp_next;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor: a default dynamic build and a
// small static build share stimulus and are compared against an array-based model.
module tb_branch_predictor;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] lk_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        clear;

   logic        a_hit, a_taken, a_mp;
   logic [31:0] a_target;
   logic [15:0] a_br, a_mpc;
   logic        b_hit, b_taken, b_mp;
   logic [31:0] b_target;
   logic [1:0]  b_br, b_mpc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   branch_predictor #(.INDEX_BITS(4), .CTR_BITS(2), .MODE(1), .STAT_WIDTH(16)) dut_a (
      .CLK(CLK), .nRST(nRST), .lk_pc(lk_pc), .lk_hit(a_hit), .lk_taken(a_taken),
      .lk_target(a_target), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target), .clear(clear), .mispredict(a_mp),
      .stat_branches(a_br), .stat_mispredicts(a_mpc));

   branch_predictor #(.INDEX_BITS(2), .CTR_BITS(1), .MODE(0), .STAT_WIDTH(2)) dut_b (
      .CLK(CLK), .nRST(nRST), .lk_pc(lk_pc), .lk_hit(b_hit), .lk_taken(b_taken),
      .lk_target(b_target), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target), .clear(clear), .mispredict(b_mp),
      .stat_branches(b_br), .stat_mispredicts(b_mpc));

   // Reference model: one table per build, parameters held as plain integers.
   int          p_ib   [2] = '{4, 2};
   int          p_cb   [2] = '{2, 1};
   int          p_mode [2] = '{1, 0};
   int          p_sw   [2] = '{16, 2};
   bit          m_valid [2][1024];
   int unsigned m_tag   [2][1024];
   int unsigned m_tgt   [2][1024];
   int          m_ctr   [2][1024];
   int unsigned m_br    [2];
   int unsigned m_mp    [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 1024; i++) begin
            m_valid[m][i] = 1'b0;
            m_tag[m][i]   = 0;
            m_tgt[m][i]   = 0;
            m_ctr[m][i]   = (1 << (p_cb[m] - 1)) - 1;
         end
         m_br[m] = 0;
         m_mp[m] = 0;
      end
   endtask

   task automatic m_lookup(input int m, input logic [31:0] pc, output bit hit,
                           output bit taken, output logic [31:0] tgt);
      int          idx;
      int unsigned tag;
      idx   = int'((pc >> 2) % (32'd1 << p_ib[m]));
      tag   = pc >> (p_ib[m] + 2);
      hit   = m_valid[m][idx] && (m_tag[m][idx] == tag);
      taken = hit && (p_mode[m] == 1) && (m_ctr[m][idx] >= (1 << (p_cb[m] - 1)));
      tgt   = taken ? m_tgt[m][idx] : pc + 32'd4;
   endtask

   function automatic bit m_mispredict();
      if (!upd_valid) return 1'b0;
      if (upd_taken != upd_pred_taken) return 1'b1;
      return upd_taken && (upd_target != upd_pred_target);
   endfunction

   task automatic m_update();
      int          idx;
      int unsigned tag;
      int          cmax;
      int unsigned smax;
      for (int m = 0; m < 2; m++) begin
         smax = (32'd1 << p_sw[m]) - 1;
         cmax = (1 << p_cb[m]) - 1;
         if (upd_valid && m_br[m] < smax) m_br[m]++;
         if (m_mispredict() && m_mp[m] < smax) m_mp[m]++;
         idx = int'((upd_pc >> 2) % (32'd1 << p_ib[m]));
         tag = upd_pc >> (p_ib[m] + 2);
         if (clear) begin
            for (int i = 0; i < 1024; i++) begin
               m_valid[m][i] = 1'b0;
               m_ctr[m][i]   = (1 << (p_cb[m] - 1)) - 1;
            end
         end else if (upd_valid) begin
            if (m_valid[m][idx] && m_tag[m][idx] == tag) begin
               if (upd_taken) begin
                  if (m_ctr[m][idx] < cmax) m_ctr[m][idx]++;
                  m_tgt[m][idx] = upd_target;
               end else if (m_ctr[m][idx] > 0) begin
                  m_ctr[m][idx]--;
               end
            end else if (upd_taken) begin
               m_valid[m][idx] = 1'b1;
               m_tag[m][idx]   = tag;
               m_tgt[m][idx]   = upd_target;
               m_ctr[m][idx]   = 1 << (p_cb[m] - 1);
            end
         end
      end
   endtask

   task automatic check_all();
      bit          hit, taken;
      logic [31:0] tgt;
      m_lookup(0, lk_pc, hit, taken, tgt);
      chk("a_hit", 32'(a_hit), 32'(hit));
      chk("a_taken", 32'(a_taken), 32'(taken));
      chk("a_target", a_target, tgt);
      chk("a_mispredict", 32'(a_mp), 32'(m_mispredict()));
      chk("a_stat_br", 32'(a_br), m_br[0]);
      chk("a_stat_mp", 32'(a_mpc), m_mp[0]);
      m_lookup(1, lk_pc, hit, taken, tgt);
      chk("b_hit", 32'(b_hit), 32'(hit));
      chk("b_taken", 32'(b_taken), 32'(taken));
      chk("b_target", b_target, tgt);
      chk("b_mispredict", 32'(b_mp), 32'(m_mispredict()));
      chk("b_stat_br", 32'(b_br), m_br[1]);
      chk("b_stat_mp", 32'(b_mpc), m_mp[1]);
   endtask

   // Called at a falling edge: drive, check pre-edge outputs, clock, advance model.
   task automatic cycle(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utg, input logic upt,
                        input logic [31:0] uptg, input logic clr);
      lk_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
      upd_pred_taken = upt; upd_pred_target = uptg; clear = clr;
      #1;
      check_all();
      @(posedge CLK);
      m_update();
      @(negedge CLK);
   endtask

   task automatic probe(input logic [31:0] pc);
      upd_valid = 1'b0; clear = 1'b0; lk_pc = pc;
      #1;
   endtask

   initial begin
      bit          h, t;
      logic [31:0] g, pc, tg, ptg;
      logic        tk, ptk;

      nRST = 1'b0; lk_pc = 32'h40; upd_valid = 1'b0; upd_pc = 0; upd_taken = 1'b0;
      upd_target = 0; upd_pred_taken = 1'b0; upd_pred_target = 0; clear = 1'b0;
      m_reset();
      #3;
      check_all();
      chk("rst_target", a_target, 32'h44);
      chk("rst_hit", 32'(a_hit), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;

      cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      probe(32'h40);
      chk("alloc_hit", 32'(a_hit), 32'd1);
      chk("alloc_taken", 32'(a_taken), 32'd1);
      chk("alloc_target", a_target, 32'h100);
      chk("alloc_br", 32'(a_br), 32'd1);
      chk("alloc_mp", 32'(a_mpc), 32'd1);
      chk("static_hit", 32'(b_hit), 32'd1);
      chk("static_taken", 32'(b_taken), 32'd0);
      chk("static_target", b_target, 32'h44);

      cycle(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
      probe(32'h40);
      chk("nt1_taken", 32'(a_taken), 32'd0);
      for (int i = 0; i < 2; i++)
         cycle(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++)
         cycle(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      probe(32'h40);
      chk("retrain_taken", 32'(a_taken), 32'd1);

      cycle(32'h80, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
      probe(32'h40);
      chk("alias_old_hit", 32'(a_hit), 32'd0);
      probe(32'h80);
      chk("alias_new_hit", 32'(a_hit), 32'd1);
      chk("alias_new_target", a_target, 32'h200);

      cycle(32'h80, 1'b1, 32'h80, 1'b1, 32'h280, 1'b1, 32'h200, 1'b0);
      probe(32'h80);
      chk("sameidx_new_target", a_target, 32'h280);

      cycle(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 32'h280, 1'b1);
      probe(32'h80);
      chk("clear_hit", 32'(a_hit), 32'd0);
      check_all();

      // Asynchronous reset in the middle of an update discards it.
      @(negedge CLK);
      upd_valid = 1'b1; upd_pc = 32'h44; upd_taken = 1'b1; upd_target = 32'h500;
      upd_pred_taken = 1'b0; clear = 1'b0; lk_pc = 32'h44;
      #2;
      nRST = 1'b0;
      #1;
      m_reset();
      chk("midrst_br", 32'(a_br), 32'd0);
      chk("midrst_hit", 32'(a_hit), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      probe(32'h44);
      chk("midrst_discard", 32'(a_hit), 32'd0);
      check_all();

      for (int i = 0; i < 5; i++)
         cycle(32'h0, 1'b1, 32'(i) << 2, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0);
      probe(32'h0);
      chk("sat2_mp", 32'(b_mpc), 32'd3);
      chk("wide_mp", 32'(a_mpc), 32'd5);

      for (int i = 0; i < 500; i++) begin
         pc  = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         tk  = 1'($urandom_range(0, 1));
         tg  = $urandom_range(0, 3) << 8;
         m_lookup(0, pc, h, t, g);
         ptk = ($urandom_range(0, 3) != 0) ? t : 1'($urandom_range(0, 1));
         ptg = ($urandom_range(0, 3) != 0) ? g : $urandom;
         cycle(($urandom_range(0, 1) != 0) ? pc :
               (($urandom_range(0, 7) << 6) | ($urandom_range(0, 15) << 2)),
               1'($urandom_range(0, 4) != 0), pc, tk, tg, ptk, ptg,
               1'($urandom_range(0, 59) == 0));
      end
      probe(32'h40);
      check_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with per-entry saturating direction counters.
- Sits in the fetch stage beside program_counter. It predicts next-PC for the fetch address in the same cycle.
- Resolved branch and jump outcomes from EX feed it back through a single update port.
- Adds dynamic prediction and misprediction accounting that the current pipeline lacks; today every branch resolves in EX and flushes IF/ID.

Parameters:
INDEX_BITS, 4, log2 of BTB entries (entries = 2**INDEX_BITS), legal range 1..10
CTR_BITS, 2, width of direction counter per entry, legal range 1..3
MODE, 1, 0 = static not-taken (never predicts taken), 1 = dynamic counter prediction
STAT_WIDTH, 16, width of the saturating statistics counters

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
lk_pc  in  32  fetch PC to look up (word_t)
lk_hit  out  1  valid entry with matching tag exists for lk_pc
lk_taken  out  1  predict taken
lk_target  out  32  predicted next PC; lk_pc+4 when lk_taken=0
upd_valid  in  1  resolved control-flow instruction this cycle
upd_pc  in  32  PC of resolved instruction
upd_taken  in  1  actual outcome
upd_target  in  32  actual taken target
upd_pred_taken  in  1  prediction that was made for this instruction
upd_pred_target  in  32  target that was predicted
clear  in  1  synchronous invalidate of all entries
mispredict  out  1  combinational: upd_valid and outcome/target disagreed with prediction
stat_branches  out  STAT_WIDTH  count of upd_valid cycles
stat_mispredicts  out  STAT_WIDTH  count of mispredict cycles

Behaviour:
- Address split: index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]. pc[1:0] ignored.
- Entry fields: valid, tag, target (32), ctr (CTR_BITS).
- Reset (nRST low, async):
  - all valid = 0, all ctr = weakly-not-taken (2**(CTR_BITS-1)-1), targets = 0.
  - stats = 0. Outputs follow combinationally: lk_hit=0, lk_taken=0, lk_target=lk_pc+4, mispredict=0 while upd_valid=0.
- Lookup: purely combinational, zero latency, reads registered table state only. No bypass from an update in the same cycle.
- Prediction:
  - lk_taken = lk_hit and ctr MSB = 1 and MODE=1. MODE=0 forces lk_taken=0; lk_hit still reports.
  - lk_target = entry target if lk_taken, else lk_pc+4 (32-bit wrap).
- mispredict:
  - asserted when upd_valid and (upd_taken != upd_pred_taken, or (upd_taken and upd_pred_taken and upd_target != upd_pred_target)).
- Update on posedge when upd_valid=1 and clear=0:
  - Hit (valid and tag match): ctr increments if taken, decrements if not taken. Saturates at 0 and 2**CTR_BITS-1. Target overwritten with upd_target when taken.
  - Miss and taken: allocate (replace). valid=1, tag, target=upd_target, ctr=weakly-taken (2**(CTR_BITS-1)).
  - Miss and not taken: no table change.
- clear=1 at posedge: all valid=0 and ctrs reset to weakly-not-taken. Overrides a simultaneous update. Statistics still count that cycle's upd_valid/mispredict.
- Statistics:
  - increment by 1 on posedge when the condition holds.
  - saturate at all-ones, never wrap.
  - cleared only by nRST.
- Simultaneous lookup and update to the same index: lookup returns pre-update state; the new state is visible the following cycle.
- Reset asserted mid-operation: table and stats clear immediately. Any update in flight is discarded.
- CTR_BITS=1: counter is a last-outcome bit. Weakly-not-taken = 0, weakly-taken = 1.

Decomposition:
- cpu_types_pkg gains:
  - btb_entry_t packed struct (valid, tag, target, ctr), sized from the parameters via a parametrised typedef inside the module.
  - constant BP_MODE_STATIC=0, BP_MODE_DYNAMIC=1.
  - word_t is used for all 32-bit ports.
- One sub-module: bp_sat_counter (parameter WIDTH).
  - Holds the pure saturating inc/dec next-value function.
  - Instantiated per entry for the direction counter and twice, with STAT_WIDTH, for the statistics.

Test Plan:
- Reset, then lk_pc=0x40 -> lk_hit=0, lk_taken=0, lk_target=0x44, stats=0.
- Update pc=0x40 taken target=0x100, pred_taken=0 -> mispredict=1 that cycle. Next cycle lk_pc=0x40 gives hit=1, taken=1, target=0x100. stat_branches=1, stat_mispredicts=1.
- Three not-taken updates at pc=0x40 after allocation:
  - first -> ctr 2->1, lk_taken=0; further -> ctr 0 and stays 0 (saturation).
  - then two taken updates -> ctr 2, lk_taken=1.
- Alias: allocate pc=0x40 (index 0, tag 1), then taken update pc=0x80 (index 0, tag 2) target=0x200 -> lk_pc=0x40 misses, lk_pc=0x80 hits to 0x200.
- Same-cycle lookup/update of 0x40 -> lk outputs show the old entry; new values appear the next cycle. clear together with upd_valid -> table empty next cycle, stat_branches still incremented.
- MODE=0 build: allocate 0x40 taken -> lk_hit=1, lk_taken=0, lk_target=0x44. STAT_WIDTH=2 with 5 mispredicts -> stat_mispredicts=3.
